// File: rtl/vga_sync_rx_if.sv
// rtl/vga_sync_rx_if.sv - VGA pin bundle and recovered-timing outputs for vga_sync_rx
interface vga_sync_rx_if;
  logic        hsync;
  logic        vsync;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [15:0] rgb_out;
  logic        de;
  logic        frame_start;
  logic        locked;
  logic        timing_err;
  logic [11:0] h_total_meas;
  logic [10:0] v_total_meas;
  logic [15:0] frame_crc;

  // master is the VGA source side, slave is the receiver
  modport master (
    output hsync, vsync, vga_r, vga_g, vga_b,
    input  pixel_x, pixel_y, rgb_out, de, frame_start, locked, timing_err,
           h_total_meas, v_total_meas, frame_crc
  );

  modport slave (
    input  hsync, vsync, vga_r, vga_g, vga_b,
    output pixel_x, pixel_y, rgb_out, de, frame_start, locked, timing_err,
           h_total_meas, v_total_meas, frame_crc
  );
endinterface

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - recovers VGA raster timing, coordinates and lock from sampled syncs
// Frame CRC-16-CCITT over active pixels is built only when VGA_RX_CRC_EN is defined.
module vga_sync_rx #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 48,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 208,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 36,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         clk_rst,
  vga_sync_rx_if.slave vif
);

  localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] H_OFF   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] V_OFF   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_MAX   = 12'hFFF;
  localparam logic [10:0] V_MAX   = 11'h7FF;
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  logic [2:0]  hs_q, vs_q;
  logic [15:0] rgb1_q, rgb2_q, rgb3_q;
  logic        h_lead, v_lead;

  logic [11:0] hcnt_q, h_len_q;
  logic [10:0] vcnt_q, v_len_q;
  logic        h_ev_q, v_ev_q;

  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        frame_bad_q, frame_bad_d;
  logic        line_bad, vlen_bad, cnt_sat;
  logic        locked_d, err_d;

  logic        active;
  logic [10:0] pixel_x_q, pixel_y_q;
  logic [15:0] rgb_out_q;
  logic        de_q, frame_start_q, locked_q, timing_err_q;
  logic [11:0] h_total_meas_q;
  logic [10:0] v_total_meas_q;

  // Sync flops reset to the asserted level so a sync already active at release is not an edge
  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      hs_q   <= {3{SYNC_POL}};
      vs_q   <= {3{SYNC_POL}};
      rgb1_q <= '0;
      rgb2_q <= '0;
      rgb3_q <= '0;
    end else begin
      hs_q   <= {hs_q[1:0], vif.hsync};
      vs_q   <= {vs_q[1:0], vif.vsync};
      rgb1_q <= {vif.vga_r, vif.vga_g, vif.vga_b};
      rgb2_q <= rgb1_q;
      rgb3_q <= rgb2_q;
    end
  end

  assign h_lead = (hs_q[1] == SYNC_POL) && (hs_q[2] != SYNC_POL);
  assign v_lead = (vs_q[1] == SYNC_POL) && (vs_q[2] != SYNC_POL);

  // Raster counters share the third stage with rgb3_q, keeping pixel data aligned
  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      h_len_q <= '0;
      v_len_q <= '0;
      h_ev_q  <= 1'b0;
      v_ev_q  <= 1'b0;
    end else begin
      h_ev_q <= h_lead;
      v_ev_q <= v_lead;
      if (h_lead) begin
        hcnt_q  <= '0;
        h_len_q <= (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 12'd1;
      end else if (hcnt_q != H_MAX) begin
        hcnt_q <= hcnt_q + 12'd1;
      end
      if (v_lead) begin
        vcnt_q  <= '0;
        v_len_q <= (vcnt_q == V_MAX) ? V_MAX : vcnt_q + 11'd1;
      end else if (h_lead && (vcnt_q != V_MAX)) begin
        vcnt_q <= vcnt_q + 11'd1;
      end
    end
  end

  assign line_bad = h_ev_q && (h_len_q != H_TOTAL);
  assign vlen_bad = v_ev_q && (v_len_q != V_TOTAL);
  assign cnt_sat  = (hcnt_q == H_MAX) || (vcnt_q == V_MAX);

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      state_q     <= S_SEARCH;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // A line closing on the vsync edge is judged before the frame it ends
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    case (state_q)
      S_SEARCH: begin
        if (v_ev_q) begin
          state_d     = S_MEASURE;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end
      end
      S_MEASURE: begin
        if (line_bad) begin
          good_d      = '0;
          frame_bad_d = 1'b1;
        end
        if (v_ev_q) begin
          frame_bad_d = 1'b0;
          if (frame_bad_q || line_bad || vlen_bad) begin
            good_d = '0;
          end else if ((good_q + 8'd1) >= LOCK_N) begin
            good_d  = '0;
            state_d = S_LOCKED;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      S_LOCKED: begin
        if (line_bad || vlen_bad || cnt_sat) begin
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    locked_d = (state_d == S_LOCKED);
    err_d    = (state_q == S_LOCKED) && (state_d == S_SEARCH);
  end

  assign active = (hcnt_q >= H_OFF) && (hcnt_q < H_END) &&
                  (vcnt_q >= V_OFF) && (vcnt_q < V_END);

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      rgb_out_q      <= '0;
      de_q           <= 1'b0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      timing_err_q   <= 1'b0;
      h_total_meas_q <= '0;
      v_total_meas_q <= '0;
    end else begin
      pixel_x_q      <= active ? 11'(hcnt_q - H_OFF) : '0;
      pixel_y_q      <= active ? (vcnt_q - V_OFF) : '0;
      rgb_out_q      <= rgb3_q;
      de_q           <= active;
      frame_start_q  <= v_ev_q;
      locked_q       <= locked_d;
      timing_err_q   <= err_d;
      h_total_meas_q <= h_len_q;
      v_total_meas_q <= v_len_q;
    end
  end

  assign vif.pixel_x      = pixel_x_q;
  assign vif.pixel_y      = pixel_y_q;
  assign vif.rgb_out      = rgb_out_q;
  assign vif.de           = de_q;
  assign vif.frame_start  = frame_start_q;
  assign vif.locked       = locked_q;
  assign vif.timing_err   = timing_err_q;
  assign vif.h_total_meas = h_total_meas_q;
  assign vif.v_total_meas = v_total_meas_q;

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  logic [15:0] crc_acc_q, frame_crc_q;

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= '0;
    end else if (frame_start_q) begin
      frame_crc_q <= crc_acc_q;
      crc_acc_q   <= 16'hFFFF;
    end else if (de_q) begin
      crc_acc_q <= crc16_step(crc_acc_q, rgb_out_q);
    end
  end

  assign vif.frame_crc = frame_crc_q;
`else
  assign vif.frame_crc = '0;
`endif

endmodule
